ddr2_seq_writer: RTL and testbench

Sequential DDR2 write-back engine: accepts a stream of 128-bit words, packs pairs into 256-bit write words, buffers them in an internal synchronous FIFO and issues them to the DDR2 controller's req/ack port at consecutive addresses from `address_bottom` to `address_top`. It is the write-direction counterpart of the sequential DDR2 reader and shares the same controller port and start/bottom control scheme, but runs entirely in the `ddr2_clk` domain.

---
 rtl/ddr2_seq_writer.sv | 112 +++++++++++
 tb/tb_ddr2_seq_writer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/ddr2_seq_writer.sv
// Sequential DDR2 write-back engine: packs 128-bit beats into 256-bit words, buffers them
// in a small FIFO and writes them to consecutive controller addresses, wrapping at the top.
module ddr2_seq_writer #(
  parameter logic [29:0] address_step    = 30'd4,
  parameter logic [29:0] address_bottom  = 30'h0000_0000,
  parameter logic [29:0] address_top     = 30'h0200_0000 - address_step,
  parameter int          fifo_depth_log2 = 4
) (
  input  logic                       ddr2_clk,
  input  logic                       RST,
  output logic                       req,
  input  logic                       ack,
  output logic [30:0]                addr,
  output logic                       read,
  output logic                       fin,
  output logic [255:0]               data_write,
  output logic [31:0]                mask,
  input  logic [127:0]               din,
  input  logic                       wr_en,
  output logic                       full,
  output logic [fifo_depth_log2:0]   count,
  input  logic                       start,
  input  logic                       bottom,
  output logic                       done
);

  localparam int DEPTH = 1 << fifo_depth_log2;
  localparam logic [fifo_depth_log2:0] FULL_COUNT = (fifo_depth_log2 + 1)'(DEPTH);

  typedef enum logic [1:0] {s_idle, s_wait, s_writing} state_t;

  state_t                     state;
  state_t                     state_next;
  logic                       half;
  logic [127:0]               low;
  logic [255:0]               mem [DEPTH];
  logic [fifo_depth_log2-1:0] wr_ptr;
  logic [fifo_depth_log2-1:0] rd_ptr;
  logic [29:0]                cur_addr;
  logic                       accept_beat;
  logic                       push;
  logic                       pop;
  logic                       at_top;

  assign full        = (count == FULL_COUNT);
  assign accept_beat = wr_en & ~full;
  assign push        = accept_beat & half;
  assign req         = (state == s_writing);
  assign pop         = req & ack;
  assign at_top      = (cur_addr == address_top);
  assign fin         = req & (at_top | (count == (fifo_depth_log2 + 1)'(1)));
  assign addr        = {1'b0, cur_addr};
  assign read        = 1'b0;
  assign mask        = 32'h0;
  assign data_write  = mem[rd_ptr];

  always_comb begin
    state_next = state;
    case (state)
      s_idle:    if (start) state_next = s_wait;
      s_wait:    if (count != '0) state_next = s_writing;
      s_writing: begin
        // Drop back to waiting only when the last buffered word leaves with nothing arriving.
        if (ack) begin
          if (at_top)
            state_next = s_idle;
          else if ((count == (fifo_depth_log2 + 1)'(1)) && !push)
            state_next = s_wait;
        end
      end
      default:   state_next = s_idle;
    endcase
  end

  always_ff @(posedge ddr2_clk) begin
    if (RST || bottom) state <= s_idle;
    else               state <= state_next;
  end

  always_ff @(posedge ddr2_clk) begin
    if (RST || bottom) begin
      half     <= 1'b0;
      low      <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      cur_addr <= address_bottom;
      done     <= 1'b0;
    end else begin
      done <= pop & at_top;
      if (accept_beat) begin
        half <= ~half;
        if (!half) low <= din;
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr   <= rd_ptr + 1'b1;
        cur_addr <= at_top ? address_bottom : cur_addr + address_step;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge ddr2_clk) begin
    if (push && !RST && !bottom) mem[wr_ptr] <= {din, low};
  end

endmodule

// File: tb/tb_ddr2_seq_writer.sv
// Directed bench for ddr2_seq_writer: a queue-based model is checked every cycle,
// with literal expectations at key points of each scenario.
module tb_ddr2_seq_writer;

  localparam logic [29:0] STEP  = 30'd4;
  localparam logic [29:0] BOT   = 30'd0;
  localparam logic [29:0] TOP   = 30'd16;
  localparam int          DLOG  = 2;
  localparam int          DEPTH = 4;
  localparam int M_IDLE = 0, M_WAIT = 1, M_WRITING = 2;

  logic           ddr2_clk;
  logic           RST;
  logic           req;
  logic           ack;
  logic [30:0]    addr;
  logic           read;
  logic           fin;
  logic [255:0]   data_write;
  logic [31:0]    mask;
  logic [127:0]   din;
  logic           wr_en;
  logic           full;
  logic [DLOG:0]  count;
  logic           start;
  logic           bottom;
  logic           done;

  int compared = 0;
  int failed   = 0;

  logic [255:0] mq[$];
  bit           mhalf;
  logic [127:0] mlow;
  int           mmode;
  logic [29:0]  maddr;
  bit           mdone;
  bit           mvalid = 0;

  ddr2_seq_writer #(
    .address_step(STEP), .address_bottom(BOT), .address_top(TOP), .fifo_depth_log2(DLOG)
  ) dut (
    .ddr2_clk(ddr2_clk), .RST(RST), .req(req), .ack(ack), .addr(addr), .read(read),
    .fin(fin), .data_write(data_write), .mask(mask), .din(din), .wr_en(wr_en),
    .full(full), .count(count), .start(start), .bottom(bottom), .done(done)
  );

  initial begin
    ddr2_clk = 1'b0;
    forever #5 ddr2_clk = ~ddr2_clk;
  end

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
    compared++;
    if (act !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Reference model: the FIFO is a plain queue of packed words.
  always @(posedge ddr2_clk) begin : modelBlk
    bit fullNow, popd, wordIn;
    if (RST || bottom) begin
      mq.delete();
      mhalf = 0; mlow = '0; mmode = M_IDLE; maddr = BOT; mdone = 0;
    end else begin
      fullNow = (mq.size() == DEPTH);
      popd    = (mmode == M_WRITING) && ack;
      wordIn  = wr_en && !fullNow && mhalf;
      mdone   = popd && (maddr == TOP);
      case (mmode)
        M_IDLE:    if (start) mmode = M_WAIT;
        M_WAIT:    if (mq.size() != 0) mmode = M_WRITING;
        default:   if (popd) begin
                     if (maddr == TOP) mmode = M_IDLE;
                     else if (mq.size() == 1 && !wordIn) mmode = M_WAIT;
                   end
      endcase
      if (popd) begin
        void'(mq.pop_front());
        maddr = (maddr == TOP) ? BOT : maddr + STEP;
      end
      if (wr_en && !fullNow) begin
        if (mhalf) begin mq.push_back({din, mlow}); mhalf = 0; end
        else       begin mlow = din; mhalf = 1; end
      end
    end
    mvalid = 1;
  end

  always @(negedge ddr2_clk) begin
    if (mvalid) begin
      checkOutput("req",   req,   mmode == M_WRITING);
      checkOutput("addr",  addr,  {1'b0, maddr});
      checkOutput("fin",   fin,   (mmode == M_WRITING) && (maddr == TOP || mq.size() == 1));
      checkOutput("count", count, mq.size());
      checkOutput("full",  full,  mq.size() == DEPTH);
      checkOutput("done",  done,  mdone);
      checkOutput("read",  read,  1'b0);
      checkOutput("mask",  mask,  32'h0);
      if (mmode == M_WRITING && mq.size() != 0) checkOutput("data_write", data_write, mq[0]);
    end
  end

  task automatic applyStimulus(input logic w, input logic [127:0] d, input logic a,
                               input logic s, input logic b);
    wr_en = w; din = d; ack = a; start = s; bottom = b;
    @(negedge ddr2_clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  function automatic logic [255:0] word(input int hi, input int lo);
    return {128'(hi), 128'(lo)};
  endfunction

  initial begin
    RST = 1'b1; wr_en = 0; din = '0; ack = 0; start = 0; bottom = 0;
    repeat (2) @(negedge ddr2_clk);
    RST = 1'b0;
    checkOutput("rst_req", req, 1'b0);
    checkOutput("rst_addr", addr, 31'd0);
    checkOutput("rst_count", count, 3'd0);
    checkOutput("rst_full", full, 1'b0);
    checkOutput("rst_done", done, 1'b0);

    // Two words to addresses 0 and 4
    applyStimulus(0, '0, 0, 1, 0);
    for (int i = 1; i <= 4; i++) applyStimulus(1, 128'(i), 0, 0, 0);
    idle(1);
    checkOutput("t1_req", req, 1'b1);
    checkOutput("t1_addr0", addr, 31'd0);
    checkOutput("t1_data0", data_write, word(2, 1));
    checkOutput("t1_fin0", fin, 1'b0);
    applyStimulus(0, '0, 1, 0, 0);
    checkOutput("t1_addr1", addr, 31'd4);
    checkOutput("t1_data1", data_write, word(4, 3));
    checkOutput("t1_fin1", fin, 1'b1);
    applyStimulus(0, '0, 1, 0, 0);
    checkOutput("t1_req_off", req, 1'b0);
    checkOutput("t1_count", count, 3'd0);

    // Ack while not requesting is ignored
    applyStimulus(0, '0, 1, 0, 0);
    checkOutput("t2_addr", addr, 31'd8);
    checkOutput("t2_count", count, 3'd0);

    applyStimulus(0, '0, 0, 0, 1);
    checkOutput("rewind_addr", addr, 31'd0);

    // Fill to full, drop two beats, drain in order
    applyStimulus(0, '0, 0, 1, 0);
    for (int i = 0; i < 8; i++) applyStimulus(1, 128'(32'h11 + i), 0, 0, 0);
    checkOutput("t4_full", full, 1'b1);
    checkOutput("t4_count", count, 3'd4);
    applyStimulus(1, 128'h19, 0, 0, 0);
    applyStimulus(1, 128'h1A, 0, 0, 0);
    checkOutput("t4_count_drop", count, 3'd4);
    for (int k = 0; k < 4; k++) begin
      checkOutput("t4_addr", addr, 31'(4 * k));
      checkOutput("t4_data", data_write, word(32'h12 + 2 * k, 32'h11 + 2 * k));
      applyStimulus(0, '0, 1, 0, 0);
    end
    checkOutput("t4_drained_req", req, 1'b0);
    checkOutput("t4_drained_count", count, 3'd0);

    // Final address of the pass, done pulse and wrap
    for (int i = 0; i < 4; i++) applyStimulus(1, 128'(32'h21 + i), 0, 0, 0);
    idle(1);
    checkOutput("t3_addr_top", addr, 31'd16);
    checkOutput("t3_fin_top", fin, 1'b1);
    checkOutput("t3_data_top", data_write, word(32'h22, 32'h21));
    applyStimulus(0, '0, 1, 0, 0);
    checkOutput("t3_done", done, 1'b1);
    checkOutput("t3_addr_wrap", addr, 31'd0);
    checkOutput("t3_req_idle", req, 1'b0);
    idle(3);
    checkOutput("t3_done_once", done, 1'b0);
    checkOutput("t3_count_held", count, 3'd1);
    checkOutput("t3_still_idle", req, 1'b0);
    applyStimulus(0, '0, 0, 1, 0);
    idle(2);
    checkOutput("t3_resume_data", data_write, word(32'h24, 32'h23));
    checkOutput("t3_resume_req", req, 1'b1);
    applyStimulus(0, '0, 1, 0, 0);

    // Push coinciding with ack at count 2
    for (int i = 0; i < 5; i++) applyStimulus(1, 128'(32'h31 + i), 0, 0, 0);
    idle(1);
    checkOutput("t5_count_pre", count, 3'd2);
    applyStimulus(1, 128'h36, 1, 0, 0);
    checkOutput("t5_count", count, 3'd2);
    checkOutput("t5_req", req, 1'b1);
    checkOutput("t5_addr", addr, 31'd8);

    // Bottom mid-burst overrides ack/start/wr_en
    applyStimulus(0, '0, 1, 0, 0);
    for (int i = 0; i < 4; i++) applyStimulus(1, 128'(32'h41 + i), 0, 0, 0);
    checkOutput("t6_addr_pre", addr, 31'd12);
    checkOutput("t6_count_pre", count, 3'd3);
    applyStimulus(1, 128'h45, 1, 1, 1);
    checkOutput("t6_req", req, 1'b0);
    checkOutput("t6_addr", addr, 31'd0);
    checkOutput("t6_count", count, 3'd0);
    idle(1);
    checkOutput("t6_idle", req, 1'b0);
    applyStimulus(0, '0, 0, 1, 0);
    applyStimulus(1, 128'h51, 0, 0, 0);
    applyStimulus(1, 128'h52, 0, 0, 0);
    idle(1);
    checkOutput("t6_restart_req", req, 1'b1);
    checkOutput("t6_restart_addr", addr, 31'd0);
    checkOutput("t6_restart_data", data_write, word(32'h52, 32'h51));
    applyStimulus(0, '0, 1, 0, 0);
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
